// File: rtl/seq_addsub_n.sv
// -----------------------------------------------------------------------------
// seq_addsub_n
//
// Digit-serial adder/subtractor. An operation is started by load, then
// processes DIGIT bits per clock, LSB slice first, and completes
// N = WIDTH/DIGIT cycles after the load edge.
//
// Optional feature macro: SEQ_ADDSUB_OVF_EN
//   defined   -> ovf reports two's-complement signed overflow
//   undefined -> ovf is tied to 0 and no overflow logic is built
//   The port list is the same in both builds.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   load  in   start request, sampled on the rising edge
//   mode  in   0 = A+B+cin, 1 = A-B-cin (cin is borrow-in)
//   A, B  in   WIDTH-bit operands, captured on an accepted load
//   cin   in   carry-in / borrow-in, captured on an accepted load
//   S     out  WIDTH-bit result, stable from done until the next accepted load
//   cout  out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf   out  signed overflow of the completed operation
//   busy  out  high while an operation is in progress
//   done  out  one-cycle pulse when S/cout/ovf are final
//
// Handshake: load is a level request with no ready. It is accepted on any
// rising edge where the block is not running (IDLE or DONE); while running
// it is ignored. done pulses for exactly one cycle per accepted load.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module seq_addsub_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // state_q is the observable FSM state for checkers
  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   s_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  // Current slice selected by the slice counter; operands are never shifted,
  // so a_q/b_q keep the captured values for the whole operation.
  logic [DIGIT-1:0]   a_sl;
  logic [DIGIT-1:0]   b_sl;
  logic [DIGIT-1:0]   sum_d;
  logic               carry_d;

  assign a_sl = a_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign b_sl = b_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign {carry_d, sum_d} = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};

`ifdef SEQ_ADDSUB_OVF_EN
  logic ovf_q;
  logic msb_carry_in;
  // Carry into the top bit of the slice recovered from the sum bit itself.
  assign msb_carry_in = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ sum_d[DIGIT-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_RUN) begin
        s_q[int'(cnt_q) * DIGIT +: DIGIT] <= sum_d;
        carry_q <= carry_d;
        if (cnt_q == LAST) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          cnt_q   <= '0;
          cout_q  <= carry_d;
`ifdef SEQ_ADDSUB_OVF_EN
          ovf_q   <= msb_carry_in ^ carry_d;
`endif
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (load) begin
        // Subtract is A + ~B + ~cin, so borrow-in becomes an inverted carry-in.
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
        a_q     <= A;
        b_q     <= mode ? ~B : B;
        carry_q <= mode ? ~cin : cin;
        cnt_q   <= '0;
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign S    = s_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SEQ_ADDSUB_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_addsub_n.sv
// -----------------------------------------------------------------------------
// tb_seq_addsub_n
//
// Two instances: 8-bit/1-bit digit (main, with a cycle-level reference model
// and a per-cycle compare process) and 16-bit/4-bit digit (directed and
// random single operations checked against the arithmetic reference function).
// -----------------------------------------------------------------------------
module tb_seq_addsub_n;

`ifdef SEQ_ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  localparam int N8  = 8;
  localparam int N16 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        load8 = 1'b0, mode8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  s8;
  logic        cout8, ovf8, busy8, done8;

  logic        load16 = 1'b0, mode16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] s16;
  logic        cout16, ovf16, busy16, done16;

  seq_addsub_n #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .load(load8), .mode(mode8), .A(a8), .B(b8),
    .cin(cin8), .S(s8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  seq_addsub_n #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .load(load16), .mode(mode16), .A(a16), .B(b16),
    .cin(cin16), .S(s16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Exact arithmetic reference: returns {ovf, cout, S} for a w-bit operation.
  function automatic logic [65:0] calc(input int w, input logic [63:0] a,
                                       input logic [63:0] b, input logic c,
                                       input logic m);
    logic [64:0] full;
    logic [63:0] mask;
    longint sa, sb, res, hi, lo;
    logic ov;
    mask = (64'd1 << w) - 64'd1;
    if (m) full = {1'b0, a} + {1'b0, (~b) & mask} + 65'(!c);
    else   full = {1'b0, a} + {1'b0, b} + 65'(c);
    sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb  = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    res = m ? sa - sb - longint'(c) : sa + sb + longint'(c);
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    ov  = (res > hi) || (res < lo);
    return {ov & OVF_ON, full[w], full[63:0] & mask};
  endfunction

  // ---------------- 8-bit cycle-level model ----------------
  // rem counts edges left until the result is due; 0 means not running.
  int          rem = 0;
  logic [65:0] pend_r = '0;
  logic        exp_done = 1'b0;
  logic [7:0]  exp_s = '0;
  logic        exp_co = 1'b0;
  logic        exp_ov = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= 0;
      exp_done <= 1'b0;
      exp_s    <= '0;
      exp_co   <= 1'b0;
      exp_ov   <= 1'b0;
    end else if (rem > 0) begin
      rem      <= rem - 1;
      exp_done <= (rem == 1);
      if (rem == 1) begin
        exp_s  <= pend_r[7:0];
        exp_co <= pend_r[64];
        exp_ov <= pend_r[65];
      end
    end else begin
      exp_done <= 1'b0;
      if (load8) begin
        pend_r <= calc(8, 64'(a8), 64'(b8), cin8, mode8);
        rem    <= N8;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("busy8", 64'(busy8), 64'(rem != 0));
    check("done8", 64'(done8), 64'(exp_done));
    if (rem == 0) begin
      check("s8",    64'(s8),    64'(exp_s));
      check("cout8", 64'(cout8), 64'(exp_co));
      check("ovf8",  64'(ovf8),  64'(exp_ov));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic m, input logic [7:0] es, input logic eco,
                     input logic eov_raw);
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; mode8 = m; load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    lat = 99;
    for (int i = 1; i <= N8 + 4; i++) begin
      @(negedge clk);
      if (done8) begin lat = i; break; end
    end
    check("lat8",      64'(lat),   64'(N8));
    check("lit_s8",    64'(s8),    64'(es));
    check("lit_cout8", 64'(cout8), 64'(eco));
    check("lit_ovf8",  64'(ovf8),  64'(eov_raw & OVF_ON));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic m, input logic [15:0] es, input logic eco,
                      input logic eov);
    int lat;
    @(negedge clk);
    a16 = a; b16 = b; cin16 = c; mode16 = m; load16 = 1'b1;
    @(negedge clk);
    load16 = 1'b0;
    lat = 99;
    for (int i = 1; i <= N16 + 4; i++) begin
      @(negedge clk);
      if (done16) begin lat = i; break; end
    end
    check("lat16",   64'(lat),    64'(N16));
    check("s16",     64'(s16),    64'(es));
    check("cout16",  64'(cout16), 64'(eco));
    check("ovf16",   64'(ovf16),  64'(eov));
    @(negedge clk);
    check("done16_pulse", 64'(done16), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [65:0] r;
    logic [15:0] ra, rb;
    logic        rc, rm;
    int          lat;

    #3;
    check("rst_s8",    64'(s8),    64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_cout8", 64'(cout8), 64'd0);
    check("rst_ovf8",  64'(ovf8),  64'd0);
    check("rst_s16",   64'(s16),   64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Literal expectations that pin the reference model
    op8(8'h0D, 8'h26, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    op8(8'h26, 8'h0D, 1'b0, 1'b1, 8'h19, 1'b1, 1'b0);
    op8(8'h0D, 8'h26, 1'b0, 1'b1, 8'hE7, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset in the middle of RUN aborts, later load works
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h33; cin8 = 1'b0; mode8 = 1'b0; load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_s8",    64'(s8),    64'd0);
    check("abort_busy8", 64'(busy8), 64'd0);
    check("abort_done8", 64'(done8), 64'd0);
    check("abort_cout8", 64'(cout8), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    op8(8'h55, 8'h33, 1'b0, 1'b0, 8'h88, 1'b0, 1'b1);

    // Load held through RUN, then back-to-back start in the done cycle
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; mode8 = 1'b0; load8 = 1'b1;
    for (int i = 1; i <= N8 + 1; i++) begin
      @(negedge clk);
      if (i <= N8) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); mode8 = 1'($urandom);
      end else begin
        check("hold_done8", 64'(done8), 64'd1);
        check("hold_s8",    64'(s8),    64'h46);
        a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; mode8 = 1'b1;
      end
    end
    @(negedge clk);
    load8 = 1'b0;
    lat = 99;
    for (int i = 1; i <= N8 + 4; i++) begin
      @(negedge clk);
      if (done8) begin lat = i; break; end
    end
    check("b2b_lat8",  64'(lat),   64'(N8));
    check("b2b_s8",    64'(s8),    64'h7F);
    check("b2b_cout8", 64'(cout8), 64'd1);
    check("b2b_ovf8",  64'(ovf8),  64'(OVF_ON));

    // Random stimulus on the 8-bit instance, checked cycle by cycle
    repeat (600) begin
      @(negedge clk);
      load8 = ($urandom_range(0, 2) == 0);
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      cin8  = 1'($urandom);
      mode8 = 1'($urandom);
    end
    @(negedge clk);
    load8 = 1'b0;
    repeat (N8 + 4) @(negedge clk);

    // 16-bit, 4-bit digit
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
    op16(16'h1234, 16'h0235, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0);
    repeat (20) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rm = 1'($urandom);
      r  = calc(16, 64'(ra), 64'(rb), rc, rm);
      op16(ra, rb, rc, rm, r[15:0], r[64], r[65]);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_addsub_n.md
SEQ_ADDSUB_N -- requirements
Module: seq_addsub_n

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal values 2..64.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  start request; sampled on a rising edge.
REQ-006 mode  input  1  operation select: 0 = add (A+B+cin), 1 = subtract (A-B-cin, cin acts as borrow-in).
REQ-007 A  input  WIDTH  first operand; captured on an accepted load.
REQ-008 B  input  WIDTH  second operand; captured on an accepted load.
REQ-009 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 S  output  WIDTH  result; held stable from done until the next accepted load.
REQ-011 cout  output  1  raw carry out of MSB; in subtract mode, 1 = no borrow.
REQ-012 ovf  output  1  two's-complement signed overflow of the completed operation.
REQ-013 busy  output  1  high while the state is RUN.
REQ-014 done  output  1  one-cycle pulse marking a valid result.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 Transitions SHALL be: IDLE->RUN on load; RUN->DONE after N digit steps; DONE->RUN on load, else DONE->IDLE.
REQ-017 An accepted load at edge k SHALL capture A, B, cin and mode.
  - Subtract: B is stored inverted; carry register initialised to ~cin.
  - Add: carry register initialised to cin.
REQ-018 Edges k+1..k+N SHALL each add one DIGIT-wide slice, LSB slice first, into S, propagating carry between slices.
REQ-019 At edge k+N the state SHALL become DONE and done SHALL rise; S, cout and ovf are final at that point.
  - Load-to-done latency = N cycles.
  - Example: WIDTH=8, DIGIT=1 gives 8 cycles.
REQ-020 done SHALL be high for exactly one cycle per operation.
REQ-021 load while in RUN SHALL be ignored, with no effect on operands or progress.
REQ-022 load sampled in DONE SHALL start a new operation with no idle cycle (back-to-back).
  - done still pulses for exactly one cycle.
  - S begins updating at edge k+1 of the new operation.
REQ-023 ovf SHALL equal (carry into MSB) XOR (carry out of MSB), computed inside the final slice for DIGIT>1.
REQ-024 Results SHALL equal the low WIDTH bits of the exact arithmetic result, with wrap-around modulo 2^WIDTH.
REQ-025 Outputs SHALL depend only on registered state (no combinational path from inputs to outputs).

Reset
REQ-026 rst=0 SHALL immediately, independent of clk, force:
  - state IDLE;
  - S=0, cout=0, ovf=0, busy=0, done=0;
  - internal operand, carry and slice-count registers to 0.
REQ-027 Reset during RUN or DONE SHALL abort the operation; no done SHALL follow.
REQ-028 After rst deassertion, the first rising edge with load=1 SHALL be accepted normally.

Configuration
REQ-029 Macro SEQ_ADDSUB_OVF_EN SHALL select signed-overflow support.
  - Defined: ovf is computed per REQ-023.
  - Undefined: ovf is tied to 0, and no overflow logic or MSB-carry register is synthesised.
  - The port list SHALL be identical in both builds.

Verification
REQ-030 WIDTH=8, DIGIT=1: add A=0x0D, B=0x26, cin=0 -> done 8 cycles after load; S=0x33, cout=0, ovf=0.
REQ-031 Subtract A=0x26, B=0x0D, cin=0 -> S=0x19, cout=1. Subtract A=0x0D, B=0x26 -> S=0xE7, cout=0.
REQ-032 Add 0x7F+0x01 -> S=0x80, ovf=1 (0 without SEQ_ADDSUB_OVF_EN). Add 0xFF+0x00, cin=1 -> S=0x00, cout=1, ovf=0.
REQ-033 Pulse rst=0 at cycle 3 of RUN -> all outputs 0 immediately; no done pulse. Load 4 cycles later -> correct result.
REQ-034 Load held high through RUN -> single operation, operands unchanged. Load in the done cycle -> second result done exactly N cycles later.
REQ-035 WIDTH=16, DIGIT=4: add 0xFFFF+0x0001 -> done after 4 cycles; S=0x0000, cout=1, ovf=0.
